// File: rtl/pwu_pkg.sv
// Shared types and default widths for the PWU retire path.
package pwu_pkg;

    localparam int unsigned PWU_DEPTH      = 4;
    localparam int unsigned PWU_SID_W      = 8;
    localparam int unsigned PWU_RSP_TYPE_W = 4;
    localparam int unsigned PWU_PKT_ID_W   = 8;
    localparam int unsigned PWU_ERR_W      = 4;
    localparam int unsigned PWU_RM_W       = 3;
    localparam int unsigned PWU_ERR_CNT_W  = 8;

    // Fields are sized to the package widths; narrower module widths zero-extend into them.
    typedef struct packed {
        logic [PWU_SID_W-1:0]      sid;
        logic [PWU_RSP_TYPE_W-1:0] rsp_type;
        logic [PWU_PKT_ID_W-1:0]   pkt_id;
        logic                      status;
        logic [PWU_ERR_W-1:0]      err_code;
        logic [PWU_RM_W-1:0]       rm;
    } pwu_retire_rec_t;

endpackage

// File: rtl/pwu_retire_err_trk.sv
// Retire-time error tracking: saturating error count and first-error capture.
module pwu_retire_err_trk
    import pwu_pkg::*;
#(
    parameter int unsigned SID_W     = PWU_SID_W,
    parameter int unsigned ERR_W     = PWU_ERR_W,
    parameter int unsigned ERR_CNT_W = PWU_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 pop,
    input  pwu_retire_rec_t      head,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_first_vld,
    output logic [SID_W-1:0]     err_first_sid,
    output logic [ERR_W-1:0]     err_first_code
);

    logic                 err_pop;
    logic [ERR_CNT_W-1:0] cnt_base;
    logic                 first_base;
    logic                 unused_fields;

    assign err_pop       = pop & head.status;
    assign unused_fields = ^{head.rsp_type, head.pkt_id, head.rm};

    // Clear takes effect before a coincident error pop is accounted.
    assign cnt_base   = err_clr ? '0 : err_cnt;
    assign first_base = err_clr ? 1'b0 : err_first_vld;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt        <= '0;
            err_first_vld  <= 1'b0;
            err_first_sid  <= '0;
            err_first_code <= '0;
        end else begin
            err_cnt       <= (err_pop && cnt_base != '1) ? cnt_base + ERR_CNT_W'(1) : cnt_base;
            err_first_vld <= first_base | err_pop;
            if (err_pop && !first_base) begin
                err_first_sid  <= SID_W'(head.sid);
                err_first_code <= ERR_W'(head.err_code);
            end
        end
    end

endmodule

// File: rtl/pwu_retire_q.sv
// DEPTH-entry retire FIFO between the PWU response generator and the NOU retire consumer.
module pwu_retire_q
    import pwu_pkg::*;
#(
    parameter int unsigned DEPTH      = PWU_DEPTH,
    parameter int unsigned SID_W      = PWU_SID_W,
    parameter int unsigned RSP_TYPE_W = PWU_RSP_TYPE_W,
    parameter int unsigned PKT_ID_W   = PWU_PKT_ID_W,
    parameter int unsigned ERR_W      = PWU_ERR_W,
    parameter int unsigned RM_W       = PWU_RM_W,
    parameter int unsigned ERR_CNT_W  = PWU_ERR_CNT_W
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [SID_W-1:0]             in_sid,
    input  logic [RSP_TYPE_W-1:0]        in_rsp_type,
    input  logic [PKT_ID_W-1:0]          in_pkt_id,
    input  logic                         in_status,
    input  logic [ERR_W-1:0]             in_err_code,
    input  logic [RM_W-1:0]              in_rm,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [SID_W-1:0]             out_sid,
    output logic [RSP_TYPE_W-1:0]        out_rsp_type,
    output logic [PKT_ID_W-1:0]          out_pkt_id,
    output logic                         out_status,
    output logic [ERR_W-1:0]             out_err_code,
    output logic [RM_W-1:0]              out_rm,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic [ERR_CNT_W-1:0]         err_cnt,
    output logic                         err_first_vld,
    output logic [SID_W-1:0]             err_first_sid,
    output logic [ERR_W-1:0]             err_first_code,
    input  logic                         err_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    pwu_retire_rec_t  mem [DEPTH];
    pwu_retire_rec_t  in_rec;
    pwu_retire_rec_t  head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign in_rdy  = (cnt != CNT_W'(DEPTH)) & ~flush;
    assign out_vld = (cnt != '0);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_comb begin
        in_rec          = '0;
        in_rec.sid      = PWU_SID_W'(in_sid);
        in_rec.rsp_type = PWU_RSP_TYPE_W'(in_rsp_type);
        in_rec.pkt_id   = PWU_PKT_ID_W'(in_pkt_id);
        in_rec.status   = in_status;
        in_rec.err_code = PWU_ERR_W'(in_err_code);
        in_rec.rm       = PWU_RM_W'(in_rm);
    end

    // Storage is not reset; head is gated by out_vld so stale entries never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
        end
    end

    assign head = out_vld ? mem[rd_ptr] : '0;

    assign out_sid      = SID_W'(head.sid);
    assign out_rsp_type = RSP_TYPE_W'(head.rsp_type);
    assign out_pkt_id   = PKT_ID_W'(head.pkt_id);
    assign out_status   = head.status;
    assign out_err_code = ERR_W'(head.err_code);
    assign out_rm       = RM_W'(head.rm);

    pwu_retire_err_trk #(
        .SID_W     (SID_W),
        .ERR_W     (ERR_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_trk (
        .clk            (clk),
        .rstn           (rstn),
        .pop            (pop),
        .head           (head),
        .err_clr        (err_clr),
        .err_cnt        (err_cnt),
        .err_first_vld  (err_first_vld),
        .err_first_sid  (err_first_sid),
        .err_first_code (err_first_code)
    );

endmodule

// File: tb/tb_pwu_retire_q.sv
// Directed self-checking bench for pwu_retire_q (DEPTH=4, ERR_CNT_W=2).
module tb_pwu_retire_q;
    import pwu_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, flush, in_vld, in_rdy, in_status, out_vld, out_rdy, out_status;
    logic [7:0] in_sid, in_pkt_id, out_sid, out_pkt_id, err_first_sid;
    logic [3:0] in_rsp_type, in_err_code, out_rsp_type, out_err_code, err_first_code;
    logic [2:0] in_rm, out_rm, cnt;
    logic [1:0] err_cnt;
    logic       err_first_vld, err_clr;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pwu_retire_q #(
        .DEPTH     (4),
        .ERR_CNT_W (2)
    ) dut (
        .clk (clk), .rstn (rstn), .flush (flush),
        .in_vld (in_vld), .in_rdy (in_rdy),
        .in_sid (in_sid), .in_rsp_type (in_rsp_type), .in_pkt_id (in_pkt_id),
        .in_status (in_status), .in_err_code (in_err_code), .in_rm (in_rm),
        .out_vld (out_vld), .out_rdy (out_rdy),
        .out_sid (out_sid), .out_rsp_type (out_rsp_type), .out_pkt_id (out_pkt_id),
        .out_status (out_status), .out_err_code (out_err_code), .out_rm (out_rm),
        .cnt (cnt), .err_cnt (err_cnt), .err_first_vld (err_first_vld),
        .err_first_sid (err_first_sid), .err_first_code (err_first_code),
        .err_clr (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [7:0] sid, input logic [7:0] pkt,
                           input logic st, input logic [3:0] code);
        in_sid = sid; in_pkt_id = pkt; in_status = st; in_err_code = code;
        in_rsp_type = sid[3:0]; in_rm = sid[2:0];
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; err_clr = 1'b0;
        set_rec(8'd0, 8'd0, 1'b0, 4'd0);
        step(); step();
        rstn = 1'b1;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_in_rdy", 32'(in_rdy), 1);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_out_sid", 32'(out_sid), 0);

        // push 1,2,3 then drain
        in_vld = 1'b1; set_rec(8'd1, 8'd1, 1'b0, 4'd0);
        step();
        chk("lat_out_vld", 32'(out_vld), 1);
        chk("lat_out_sid", 32'(out_sid), 1);
        chk("lat_out_rsp_type", 32'(out_rsp_type), 1);
        set_rec(8'd2, 8'd2, 1'b0, 4'd0); step();
        set_rec(8'd3, 8'd3, 1'b0, 4'd0); step();
        in_vld = 1'b0;
        chk("pp_cnt3", 32'(cnt), 3);
        out_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("pp_out_sid", 32'(out_sid), 32'(i));
            step();
        end
        chk("pp_empty_vld", 32'(out_vld), 0);
        chk("pp_empty_sid", 32'(out_sid), 0);
        out_rdy = 1'b0;

        // fill to full
        in_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rec(8'(10 + i), 8'd0, 1'b0, 4'd0);
            #1;
            chk("full_in_rdy", 32'(in_rdy), (i < 4) ? 1 : 0);
            if (i < 4) step();
        end
        chk("full_cnt", 32'(cnt), 4);
        out_rdy = 1'b1;
        #1;
        chk("full_pop_in_rdy", 32'(in_rdy), 0);
        step();
        in_vld = 1'b0; out_rdy = 1'b0;
        chk("full_after_pop_cnt", 32'(cnt), 3);
        chk("full_after_pop_sid", 32'(out_sid), 11);
        out_rdy = 1'b1;
        for (int i = 11; i <= 13; i++) begin
            chk("full_drain_sid", 32'(out_sid), 32'(i));
            step();
        end
        chk("full_drained_cnt", 32'(cnt), 0);

        // wrap: back-to-back push+pop
        in_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rec(8'(40 + i), 8'(i), 1'b0, 4'd0);
            step();
            chk("wrap_pkt_id", 32'(out_pkt_id), 32'(i));
            chk("wrap_cnt", 32'(cnt), 1);
        end
        in_vld = 1'b0;
        step();
        chk("wrap_end_cnt", 32'(cnt), 0);
        out_rdy = 1'b0;

        // flush with a push in flight
        in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rec(8'(20 + i), 8'd0, 1'b0, 4'd0);
            step();
        end
        chk("fl_pre_cnt", 32'(cnt), 3);
        flush = 1'b1; set_rec(8'd23, 8'd0, 1'b0, 4'd0);
        #1;
        chk("fl_in_rdy", 32'(in_rdy), 0);
        step();
        flush = 1'b0; in_vld = 1'b0;
        chk("fl_cnt", 32'(cnt), 0);
        chk("fl_out_vld", 32'(out_vld), 0);
        chk("fl_err_cnt", 32'(err_cnt), 0);
        step();
        chk("fl_no_push_cnt", 32'(cnt), 0);

        // errors
        in_vld = 1'b1;
        set_rec(8'd5, 8'd0, 1'b1, 4'h3); step();
        set_rec(8'd6, 8'd0, 1'b1, 4'h9); step();
        in_vld = 1'b0;
        chk("err_not_on_push", 32'(err_cnt), 0);
        out_rdy = 1'b1;
        step(); step();
        out_rdy = 1'b0;
        chk("err_cnt2", 32'(err_cnt), 2);
        chk("err_first_vld", 32'(err_first_vld), 1);
        chk("err_first_sid", 32'(err_first_sid), 5);
        chk("err_first_code", 32'(err_first_code), 3);
        in_vld = 1'b1; set_rec(8'd7, 8'd0, 1'b1, 4'hA); step();
        in_vld = 1'b0; out_rdy = 1'b1; err_clr = 1'b1;
        step();
        err_clr = 1'b0; out_rdy = 1'b0;
        chk("clr_pop_err_cnt", 32'(err_cnt), 1);
        chk("clr_pop_first_vld", 32'(err_first_vld), 1);
        chk("clr_pop_first_sid", 32'(err_first_sid), 7);
        chk("clr_pop_first_code", 32'(err_first_code), 32'hA);
        in_vld = 1'b1; set_rec(8'd8, 8'd0, 1'b0, 4'h1); step();
        in_vld = 1'b0; out_rdy = 1'b1; step(); out_rdy = 1'b0;
        chk("ok_pop_err_cnt", 32'(err_cnt), 1);

        // clear, then saturate
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 0);
        chk("clr_first_vld", 32'(err_first_vld), 0);
        chk("clr_first_sid_hold", 32'(err_first_sid), 7);
        in_vld = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rec(8'(30 + i), 8'd0, 1'b1, 4'(i + 1));
            step();
        end
        in_vld = 1'b0;
        step();
        out_rdy = 1'b0;
        chk("sat_err_cnt", 32'(err_cnt), 3);
        chk("sat_first_sid", 32'(err_first_sid), 30);
        chk("sat_first_code", 32'(err_first_code), 1);

        // reset mid-stream
        in_vld = 1'b1;
        set_rec(8'd50, 8'd0, 1'b1, 4'h2); step();
        set_rec(8'd51, 8'd0, 1'b1, 4'h2); step();
        chk("mid_pre_cnt", 32'(cnt), 2);
        rstn = 1'b0; out_rdy = 1'b1;
        step();
        chk("mid_rst_cnt", 32'(cnt), 0);
        chk("mid_rst_out_vld", 32'(out_vld), 0);
        chk("mid_rst_out_sid", 32'(out_sid), 0);
        chk("mid_rst_out_status", 32'(out_status), 0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 1);
        chk("mid_rst_err_cnt", 32'(err_cnt), 0);
        chk("mid_rst_first_vld", 32'(err_first_vld), 0);
        chk("mid_rst_first_sid", 32'(err_first_sid), 0);
        chk("mid_rst_first_code", 32'(err_first_code), 0);
        in_vld = 1'b0; out_rdy = 1'b0; rstn = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
